// File: rtl/dma_rd_engine_if.sv
// Signal bundle between the DMA read engine, its command source, host memory and the read-data sink.
// The master modport is the engine's view; slave is the view of everything around it.
interface dma_rd_engine_if;
    logic         rcc_valid;
    logic         rcc_ready;
    logic [39:0]  rcc_dram_addr;
    logic [15:0]  rcc_dpram_addr;
    logic [15:0]  rcc_length;

    logic         mem_req;
    logic [39:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;

    logic         rcd_valid;
    logic         rcd_ready;
    logic [15:0]  rcd_dpram_addr;
    logic [127:0] rcd_data;
    logic [15:0]  rcd_length;
    logic         rcd_last;
    logic         busy;
    logic [31:0]  rd_beat_count;

    modport master (
        input  rcc_valid, rcc_dram_addr, rcc_dpram_addr, rcc_length,
        input  mem_gnt, mem_rvalid, mem_rdata,
        input  rcd_ready,
        output rcc_ready, mem_req, mem_addr,
        output rcd_valid, rcd_dpram_addr, rcd_data, rcd_length, rcd_last,
        output busy, rd_beat_count
    );

    modport slave (
        output rcc_valid, rcc_dram_addr, rcc_dpram_addr, rcc_length,
        output mem_gnt, mem_rvalid, mem_rdata,
        output rcd_ready,
        input  rcc_ready, mem_req, mem_addr,
        input  rcd_valid, rcd_dpram_addr, rcd_data, rcd_length, rcd_last,
        input  busy, rd_beat_count
    );
endinterface

// File: rtl/dma_rd_engine.sv
// DMA read engine: splits a command into 128-bit host reads and streams the returned beats out in order.
// Define DMA_RD_STATS_EN to build the saturating popped-beat counter on rd_beat_count.
module dma_rd_engine #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = 16
) (
    input  logic            clk,
    input  logic            rst,
    dma_rd_engine_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        r_state;
    state_t        w_next;

    logic [39:0]   r_addr;
    logic [15:0]   r_dpram;
    logic [15:0]   r_len;
    logic [15:0]   r_issued;
    logic [15:0]   r_popped;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [127:0]  r_fifo [FIFO_DEPTH];

    logic          w_rcc_ready;
    logic          w_req;
    logic          w_accept;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic          w_credit;
    logic          w_final_pop;

    // Buffered beats count against the credit too, so a stalled sink can never overflow the FIFO.
    assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH);
    assign w_accept    = bus.rcc_valid && w_rcc_ready;
    assign w_gnt       = w_req && bus.mem_gnt;
    assign w_push      = bus.mem_rvalid && (r_outstanding != '0);
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && bus.rcd_ready;
    assign w_final_pop = w_pop && (r_popped == r_len - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rcc_ready = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            IDLE: begin
                w_rcc_ready = 1'b1;
                if (bus.rcc_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_req = (r_issued < r_len) && w_credit;
                if (r_len == 16'd0) begin
                    w_next = IDLE;
                end else if (w_req && bus.mem_gnt && (r_issued + 16'd1 == r_len)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final_pop) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_dpram       <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_popped      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_accept) begin
                r_addr        <= bus.rcc_dram_addr;
                r_dpram       <= bus.rcc_dpram_addr;
                r_len         <= bus.rcc_length;
                r_issued      <= '0;
                r_popped      <= '0;
                r_outstanding <= '0;
            end else begin
                if (w_gnt) begin
                    r_issued <= r_issued + 16'd1;
                end
                if (w_pop) begin
                    r_popped <= r_popped + 16'd1;
                end
                r_outstanding <= r_outstanding + CW'(w_gnt) - CW'(w_push);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is only exposed while the occupancy count says it is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= bus.mem_rdata;
        end
    end

    assign bus.rcc_ready      = w_rcc_ready;
    assign bus.mem_req        = w_req;
    assign bus.mem_addr       = r_addr + 40'(r_issued) * 40'(ADDR_STEP);
    assign bus.rcd_valid      = w_valid;
    assign bus.rcd_data       = w_valid ? r_fifo[r_rptr] : '0;
    assign bus.rcd_dpram_addr = r_dpram + r_popped;
    assign bus.rcd_length     = r_len;
    assign bus.rcd_last       = w_valid && (r_popped == r_len - 16'd1);
    assign bus.busy           = (r_state != IDLE);

`ifdef DMA_RD_STATS_EN
    logic [31:0] r_beat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (w_pop && (r_beat_count != 32'hFFFF_FFFF)) begin
            r_beat_count <= r_beat_count + 32'd1;
        end
    end

    assign bus.rd_beat_count = r_beat_count;
`else
    assign bus.rd_beat_count = 32'd0;
`endif

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine with a host-memory responder answering each grant two cycles later.
// Expected addresses, data and beat indices are computed from the command the bench issues.
module tb_dma_rd_engine;
    typedef struct {
        int          due;
        logic [39:0] addr;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          respDelay = 2;
    int          strayPending = 0;
    resp_t       pendQ[$];

    logic [39:0]  cmdAddr;
    logic [15:0]  cmdDpram;
    int           cmdLen;
    int           tbIssued;
    int           tbBeats;
    logic         stalled;
    logic [127:0] stallData;
    logic         reqWait;
    logic [39:0]  reqAddr;
    int           expStats;

    dma_rd_engine_if bus();

    dma_rd_engine #(
        .FIFO_DEPTH(4),
        .ADDR_STEP (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] beatData(input logic [39:0] a);
        return {a, 8'h5A, ~a, a + 40'h00_0000_0123};
    endfunction

    // Record every accepted request so its data can be returned in order later.
    always @(posedge clk) begin
        cycle++;
        if (!rst && bus.mem_req && bus.mem_gnt) begin
            pendQ.push_back('{cycle + respDelay, bus.mem_addr});
        end
    end

    always @(negedge clk) begin
        if (strayPending > 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
            strayPending--;
        end else if (pendQ.size() > 0 && pendQ[0].due <= cycle + 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beatData(pendQ[0].addr);
            void'(pendQ.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_rcc_ready", bus.rcc_ready, 1'b1);
        checkOutput("rst_mem_req", bus.mem_req, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 40'h0);
        checkOutput("rst_rcd_valid", bus.rcd_valid, 1'b0);
        checkOutput("rst_rcd_last", bus.rcd_last, 1'b0);
        checkOutput("rst_rcd_dpram_addr", bus.rcd_dpram_addr, 16'h0);
        checkOutput("rst_rcd_length", bus.rcd_length, 16'h0);
        checkOutput("rst_rcd_data", bus.rcd_data, 128'h0);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_rd_beat_count", bus.rd_beat_count, 32'h0);
    endtask

    // Called on a falling edge; returns on the falling edge after the command was accepted.
    task automatic sendCommand(input logic [39:0] a, input logic [15:0] d, input int len);
        cmdAddr  = a;
        cmdDpram = d;
        cmdLen   = len;
        tbIssued = 0;
        tbBeats  = 0;
        stalled  = 1'b0;
        reqWait  = 1'b0;
        bus.rcc_valid      = 1'b1;
        bus.rcc_dram_addr  = a;
        bus.rcc_dpram_addr = d;
        bus.rcc_length     = 16'(len);
        checkOutput("rcc_ready_idle", bus.rcc_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.rcc_valid = 1'b0;
        checkOutput("busy_after_accept", bus.busy, 1'b1);
        checkOutput("rcc_ready_busy", bus.rcc_ready, 1'b0);
    endtask

    // readyMode: 0 always ready, 1 toggling, 2 never ready. gntMode: 0 always grant, 1 random.
    task automatic applyStimulus(input int target, input int readyMode, input int gntMode, input int budget);
        logic [39:0] expAddr;
        for (int cyc = 0; cyc < budget && tbBeats < target; cyc++) begin
            if (reqWait) begin
                checkOutput("req_hold", bus.mem_req, 1'b1);
                checkOutput("addr_hold", bus.mem_addr, reqAddr);
            end
            if (stalled) begin
                checkOutput("rcd_stable", bus.rcd_data, stallData);
            end
            bus.mem_gnt = (gntMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (readyMode)
                0:       bus.rcd_ready = 1'b1;
                1:       bus.rcd_ready = (cyc % 2 == 0);
                default: bus.rcd_ready = 1'b0;
            endcase
            if (bus.mem_req && bus.mem_gnt) begin
                expAddr = cmdAddr + 40'(tbIssued) * 40'd16;
                checkOutput("mem_addr", bus.mem_addr, expAddr);
                tbIssued++;
            end
            reqWait   = bus.mem_req && !bus.mem_gnt;
            reqAddr   = bus.mem_addr;
            stalled   = bus.rcd_valid && !bus.rcd_ready;
            stallData = bus.rcd_data;
            if (bus.rcd_valid && bus.rcd_ready) begin
                checkOutput("rcd_data", bus.rcd_data, beatData(cmdAddr + 40'(tbBeats) * 40'd16));
                checkOutput("rcd_dpram_addr", bus.rcd_dpram_addr, 16'(cmdDpram + 16'(tbBeats)));
                checkOutput("rcd_last", bus.rcd_last, 1'(tbBeats == cmdLen - 1));
                checkOutput("rcd_length", bus.rcd_length, 16'(cmdLen));
                tbBeats++;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkDone();
        checkOutput("beats_delivered", 128'(tbBeats), 128'(cmdLen));
        checkOutput("requests_issued", 128'(tbIssued), 128'(cmdLen));
        checkOutput("busy_end", bus.busy, 1'b0);
        checkOutput("rcc_ready_end", bus.rcc_ready, 1'b1);
        checkOutput("rcd_valid_end", bus.rcd_valid, 1'b0);
        bus.mem_gnt   = 1'b0;
        bus.rcd_ready = 1'b0;
    endtask

    initial begin
`ifdef DMA_RD_STATS_EN
        expStats = 8;
`else
        expStats = 0;
`endif
        rst                = 1'b1;
        bus.rcc_valid      = 1'b0;
        bus.rcc_dram_addr  = '0;
        bus.rcc_dpram_addr = '0;
        bus.rcc_length     = '0;
        bus.mem_gnt        = 1'b0;
        bus.rcd_ready      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        rst = 1'b0;
        @(negedge clk);

        // Basic four-beat transfer.
        sendCommand(40'h00_0000_1000, 16'h0010, 4);
        applyStimulus(4, 0, 0, 60);
        checkDone();
        @(negedge clk);

        // Sink stalled: only FIFO_DEPTH requests may be outstanding-or-buffered.
        sendCommand(40'h00_0000_8000, 16'h0100, 8);
        applyStimulus(8, 2, 0, 12);
        checkOutput("credit_grants", 128'(tbIssued), 128'd4);
        checkOutput("credit_req_low", bus.mem_req, 1'b0);
        checkOutput("credit_rcd_valid", bus.rcd_valid, 1'b1);
        applyStimulus(8, 0, 0, 100);
        checkDone();
        @(negedge clk);

        // Zero-length command.
        sendCommand(40'h00_0000_3000, 16'h0020, 0);
        checkOutput("len0_mem_req", bus.mem_req, 1'b0);
        checkOutput("len0_rcd_valid", bus.rcd_valid, 1'b0);
        @(negedge clk);
        checkOutput("len0_mem_req_after", bus.mem_req, 1'b0);
        checkOutput("len0_rcd_valid_after", bus.rcd_valid, 1'b0);
        checkOutput("len0_busy_after", bus.busy, 1'b0);
        checkOutput("len0_rcc_ready_after", bus.rcc_ready, 1'b1);

        // Toggling sink, random grants, address and dpram wrap.
        sendCommand(40'hFF_FFFF_FFD0, 16'hFFFE, 6);
        applyStimulus(6, 1, 1, 300);
        checkDone();
        @(negedge clk);

        // Reset mid-transfer with responses still in flight.
        sendCommand(40'h20_0000_0000, 16'h0200, 6);
        applyStimulus(2, 0, 0, 40);
        checkOutput("beats_before_rst", 128'(tbBeats), 128'd2);
        rst           = 1'b1;
        bus.mem_gnt   = 1'b0;
        bus.rcd_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetValues();
        strayPending = 2;
        bus.rcd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stray_rcd_valid", bus.rcd_valid, 1'b0);
            checkOutput("stray_busy", bus.busy, 1'b0);
            checkOutput("stray_mem_req", bus.mem_req, 1'b0);
        end
        bus.rcd_ready = 1'b0;
        sendCommand(40'h00_0000_5000, 16'hFFFF, 1);
        applyStimulus(1, 0, 0, 30);
        checkDone();
        @(negedge clk);

        // Fresh reset, then two commands totalling eight beats for the statistics counter.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("stats_after_rst", bus.rd_beat_count, 32'h0);
        sendCommand(40'h00_0000_4000, 16'h0300, 3);
        applyStimulus(3, 0, 0, 50);
        checkDone();
        @(negedge clk);
        sendCommand(40'h00_0000_6000, 16'h0400, 5);
        applyStimulus(5, 0, 0, 60);
        checkDone();
        @(negedge clk);
        checkOutput("rd_beat_count", bus.rd_beat_count, 32'(expStats));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_rd_engine.md
DMA_RD_ENGINE -- requirements
Module: dma_rd_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning response buffer entries and maximum outstanding host reads (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_STEP, default 16, meaning host byte-address increment per 128-bit beat.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have read-command ports: rcc_valid in 1; rcc_ready out 1; rcc_dram_addr in 40 host byte address; rcc_dpram_addr in 16 local word address; rcc_length in 16 beat count.
REQ-005 SHALL have host-memory ports: mem_req out 1; mem_addr out 40; mem_gnt in 1 request accepted; mem_rvalid in 1; mem_rdata in 128, in-order, one per grant, no backpressure.
REQ-006 SHALL have read-data ports: rcd_valid out 1; rcd_ready in 1; rcd_dpram_addr out 16; rcd_data out 128; rcd_length out 16 latched command length; rcd_last out 1; busy out 1; rd_beat_count out 32.

Function
REQ-007 SHALL implement states IDLE, ISSUE, DRAIN; busy = (state != IDLE).
REQ-008 SHALL assert rcc_ready only in IDLE; on rcc_valid && rcc_ready SHALL latch addr/dpram_addr/length, clear counters, go to ISSUE next cycle.
REQ-009 SHALL, for rcc_length == 0, accept the command, emit no mem_req and no rcd beat, and return to IDLE the cycle after acceptance.
REQ-010 SHALL, in ISSUE, assert mem_req when issued < length and (outstanding + fifo_count) < FIFO_DEPTH; mem_addr = latched addr + issued*ADDR_STEP, 40-bit wrap.
REQ-011 SHALL hold mem_req and mem_addr stable until mem_gnt; a grant increments issued and outstanding.
REQ-012 SHALL push mem_rdata into the FIFO on mem_rvalid while outstanding > 0, decrementing outstanding; mem_rvalid with outstanding == 0 SHALL be ignored.
REQ-013 SHALL go ISSUE -> DRAIN on the cycle issued reaches length; DRAIN -> IDLE on the pop of the final beat.
REQ-014 SHALL present FIFO head on rcd_*; rcd_valid = FIFO non-empty; pop on rcd_valid && rcd_ready; rcd_data stable while rcd_valid && !rcd_ready.
REQ-015 SHALL set rcd_dpram_addr = latched dpram_addr + popped-beat index (16-bit wrap); rcd_last = 1 on beat index length-1 only.
REQ-016 SHALL support same-cycle push and pop, including at FIFO full; credit rule REQ-010 guarantees no overflow; first beat latency mem_rvalid -> rcd_valid is 1 cycle.
REQ-017 SHALL support grant, rvalid and pop in the same cycle with counters updated consistently.

Reset
REQ-018 SHALL, on rst, drive state IDLE, rcc_ready 1, mem_req 0, mem_addr 0, rcd_valid 0, rcd_last 0, rcd_dpram_addr 0, rcd_length 0, rcd_data 0, busy 0, rd_beat_count 0, empty FIFO, all counters 0.
REQ-019 SHALL, on rst mid-transfer, abandon the command; responses arriving after reset SHALL be discarded per REQ-012.

Configuration
REQ-020 SHALL gate beat statistics with macro DMA_RD_STATS_EN: defined -> rd_beat_count increments (saturating at 2^32-1) on every rcd pop, cleared only by rst; undefined -> rd_beat_count tied to 0, no counter logic.

Verification
REQ-021 SHALL cover: cmd addr 0x0000001000, dpram 0x0010, len 4, mem_gnt=1, rvalid 2 cycles after grant, rcd_ready=1 -> mem_addr 0x1000,0x1010,0x1020,0x1030; rcd_dpram_addr 0x10..0x13; rcd_last on 4th beat; busy drops after last pop.
REQ-022 SHALL cover: len 8, FIFO_DEPTH 4, rcd_ready=0 -> exactly 4 grants then mem_req low; raising rcd_ready resumes issue; all 8 beats delivered in order.
REQ-023 SHALL cover: len 0 -> rcc_ready low for one cycle, no mem_req, no rcd_valid, rcc_ready high again.
REQ-024 SHALL cover: rcd_ready toggling 1/0 each cycle, mem_gnt random -> data order and values match mem_rdata sequence; rcd_data stable while stalled.
REQ-025 SHALL cover: rst asserted after 2 of 6 beats with 2 outstanding, then stray mem_rvalid x2 -> all REQ-018 values; no rcd_valid; new len-1 command completes correctly.
REQ-026 SHALL cover: with DMA_RD_STATS_EN, two commands len 3 and 5 -> rd_beat_count 8; without macro -> rd_beat_count 0.
